// File: rtl/mem_access_unit.sv
// Memory stage: single-word loads/stores plus two-cycle 32-bit PC push/pop on a 16-bit data memory.
// Two-word ops raise Stall in the accepting IDLE cycle; Stall drops in the second cycle.
module mem_access_unit #(
  parameter int          ADDR_BITS = 12,
  parameter logic [11:0] INIT_SP   = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MR,
  input  logic        MW,
  input  logic        WB,
  input  logic        SP,
  input  logic        SPOP,
  input  logic        Stack_PC,
  input  logic        Stack_Flags,
  input  logic [2:0]  WB_Address,
  input  logic [31:0] Data,
  input  logic [31:0] Address,
  input  logic [2:0]  Final_Flags,
  output logic        Stall,
  output logic        WB_Out,
  output logic [2:0]  WB_Address_Out,
  output logic [15:0] WB_Data,
  output logic [31:0] PC_Out,
  output logic        PC_Valid,
  output logic [2:0]  Flags_From_Memory,
  output logic        Flags_Valid
);

  typedef enum logic [1:0] {IDLE, PUSH_LO, POP_HI} state_t;

  state_t               state;
  logic [15:0]          mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] pend_addr;
  logic [15:0]          pend_lo;
  logic                 is_push;
  logic                 is_pop;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] we_addr;
  logic [15:0]          we_data;
  logic                 unused_ok;

  // SP/SPOP, the upper address bits and INIT_SP carry no behaviour here.
  assign unused_ok = &{1'b0, SP, SPOP, Address[31:ADDR_BITS], INIT_SP};

  assign addr    = Address[ADDR_BITS-1:0];
  assign is_push = Stack_PC & MW;
  assign is_pop  = Stack_PC & MR & ~MW;
  assign Stall   = ~rst && (state == IDLE) && (is_push || is_pop);

  always_comb begin
    mem_we  = 1'b0;
    we_addr = addr;
    we_data = Data[15:0];
    if (!rst) begin
      case (state)
        IDLE: begin
          if (MW) begin
            mem_we = 1'b1;
            if (Stack_PC)         we_data = Data[31:16];
            else if (Stack_Flags) we_data = {13'b0, Final_Flags};
          end
        end
        PUSH_LO: begin
          mem_we  = 1'b1;
          we_addr = pend_addr;
          we_data = pend_lo;
        end
        default: ;
      endcase
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[we_addr] <= we_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      WB_Out            <= 1'b0;
      WB_Address_Out    <= 3'b0;
      WB_Data           <= 16'b0;
      PC_Out            <= 32'b0;
      PC_Valid          <= 1'b0;
      Flags_From_Memory <= 3'b0;
      Flags_Valid       <= 1'b0;
      pend_addr         <= '0;
      pend_lo           <= 16'b0;
    end else begin
      PC_Valid    <= 1'b0;
      Flags_Valid <= 1'b0;
      case (state)
        IDLE: begin
          WB_Address_Out <= WB_Address;
          if (is_push) begin
            WB_Out    <= 1'b0;
            pend_addr <= addr - ADDR_BITS'(1);
            pend_lo   <= Data[15:0];
            state     <= PUSH_LO;
          end else if (is_pop) begin
            WB_Out    <= 1'b0;
            pend_addr <= addr + ADDR_BITS'(1);
            pend_lo   <= mem[addr];
            state     <= POP_HI;
          end else begin
            WB_Out <= WB;
            if (MR && !MW) begin
              WB_Data <= mem[addr];
              if (Stack_Flags) begin
                Flags_From_Memory <= mem[addr][2:0];
                Flags_Valid       <= 1'b1;
              end
            end else begin
              WB_Data <= Data[15:0];
            end
          end
        end
        PUSH_LO: begin
          WB_Out <= 1'b0;
          state  <= IDLE;
        end
        POP_HI: begin
          WB_Out   <= 1'b0;
          PC_Out   <= {mem[pend_addr], pend_lo};
          PC_Valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, giving the word-address width of the internal data memory (2^ADDR_BITS x 16-bit words).
REQ-002 SHALL have parameter INIT_SP, default 12'hFFF; it is documentation only and SHALL NOT affect logic.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 MR, MW, WB, SP, SPOP, Stack_PC, Stack_Flags  input  1 each  EX/MEM control bits.
REQ-006 WB_Address  input  3  destination register index.
REQ-007 Data  input  32  EX/MEM data; PC for Stack_PC pushes, else {16'b0, value}.
REQ-008 Address  input  32  EX/MEM word address; bits [ADDR_BITS-1:0] used, upper bits ignored.
REQ-009 Final_Flags  input  3  {NF,CF,ZF} from EX.
REQ-010 Stall  output  1  combinational; freezes upstream pipeline registers for one cycle.
REQ-011 WB_Out, WB_Address_Out[2:0], WB_Data[15:0]  output  registered MEM/WB fields.
REQ-012 PC_Out[31:0], PC_Valid  output  registered popped PC and 1-cycle strobe.
REQ-013 Flags_From_Memory[2:0], Flags_Valid  output  registered popped flags and 1-cycle strobe.

Function
REQ-014 SHALL implement FSM states IDLE, PUSH_LO, POP_HI; reset state IDLE.
REQ-015 In IDLE, an operation is accepted every cycle; access address A = Address[ADDR_BITS-1:0].
REQ-016 MW=1 and MR=1 simultaneously SHALL be treated as a write; no read occurs.
REQ-017 Single-word write (MW=1, Stack_PC=0): mem[A] <= Stack_Flags ? {13'b0, Final_Flags} : Data[15:0], on the accepting edge.
REQ-018 Single-word read (MR=1, MW=0, Stack_PC=0): WB_Data <= mem[A] on the accepting edge (1-cycle latency, read-before-write with same-edge writes).
REQ-019 Read with Stack_Flags=1: Flags_From_Memory <= mem[A][2:0], Flags_Valid <= 1 for exactly one cycle; WB_Data still loaded.
REQ-020 No memory op (MR=MW=0): WB_Data <= Data[15:0].
REQ-021 WB_Out <= WB and WB_Address_Out <= WB_Address on every accepting edge; Stall cycles SHALL hold WB_Out at 0.
REQ-022 PC push (Stack_PC=1, MW=1) in IDLE: Stall=1 that cycle; edge writes mem[A] <= Data[31:16], latches A-1 and Data[15:0], goes to PUSH_LO.
REQ-023 PUSH_LO: Stall=0; edge writes mem[A-1] <= latched low half, returns to IDLE; inputs presented this cycle are ignored (upstream was held).
REQ-024 PC pop (Stack_PC=1, MR=1, MW=0) in IDLE: Stall=1; edge latches mem[A] as low half, latches A+1, goes to POP_HI.
REQ-025 POP_HI: Stall=0; edge sets PC_Out <= {mem[A+1], latched low}, PC_Valid <= 1 for one cycle, returns to IDLE.
REQ-026 Address arithmetic A-1 / A+1 SHALL wrap modulo 2^ADDR_BITS (0-1 -> max, max+1 -> 0).
REQ-027 Stall SHALL be 0 in all states except the IDLE cycle accepting a two-word op.
REQ-028 PC_Valid and Flags_Valid SHALL never be high for two consecutive cycles from one op.

Reset
REQ-029 On rst: state <= IDLE; WB_Out, PC_Valid, Flags_Valid <= 0; WB_Address_Out, WB_Data, PC_Out, Flags_From_Memory <= 0; Stall = 0 the following cycle.
REQ-030 rst SHALL NOT clear memory contents; rst mid two-word op SHALL abort it, leaving any first-half write in place and no PC_Valid.
REQ-031 rst SHALL take priority over any simultaneous input operation.

Verification
REQ-032 Write Data=0x00AB to A=0x010, then read A=0x010 with WB=1, WB_Address=5 -> next cycle WB_Data=0x00AB, WB_Out=1, WB_Address_Out=5.
REQ-033 Push PC Data=0x1234_5678 at A=0xFFF -> Stall=1 one cycle; mem[0xFFF]=0x1234, mem[0xFFE]=0x5678; then pop at A=0xFFE -> Stall=1 one cycle, then PC_Out=0x12345678, PC_Valid pulse of 1 cycle.
REQ-034 Push PC at A=0x000 -> low half lands at 0xFFF (wrap); pop at 0xFFF reads high from 0x000.
REQ-035 Flags push Final_Flags=3'b101 at A=0x020, then flags pop at A=0x020 -> Flags_From_Memory=3'b101, Flags_Valid one cycle.
REQ-036 Assert rst in PUSH_LO of a push of 0xAAAA_BBBB at A=0x100 -> mem[0x100]=0xAAAA, mem[0x0FF] unchanged, all outputs 0 next cycle, state IDLE.
REQ-037 MR=MW=1, Data=0x0042, A=0x030 -> mem[0x030]=0x0042, WB_Data=0x0042 (no read).
